// File: rtl/osc_freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of an asynchronous
// oscillator over a fixed window of GATE_CYCLES clocks and latches the result.
module osc_freq_meter #(
    parameter int GATE_CYCLES = 10000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc_in,
    input  logic             enable,
    input  logic             start,
    input  logic             byte_sel,
    output logic [CNT_W-1:0] meas,
    output logic             meas_valid,
    output logic             ovf,
    output logic             busy,
    output logic [7:0]       dout
);

    localparam int TW = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(GATE_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_GATE
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic [CNT_W-1:0]       r_edge_cnt;
    logic [TW-1:0]          r_timer;
    logic                   r_sat_flag;
    logic [CNT_W-1:0]       r_meas;
    logic                   r_ovf;
    logic                   r_meas_valid;
    logic                   r_busy;

    logic                   w_edge;
    logic                   w_sat_now;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [7:0]             w_dout;

    // Returns {saturated, next_count}; the count sticks at all-ones.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             inc);
        logic sat;
        sat = inc & (&cnt);
        if (sat)
            return {1'b1, cnt};
        else
            return {1'b0, cnt + CNT_W'(inc)};
    endfunction

    // Synchronizer front end, running in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], osc_in};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge                  = r_sync[SYNC_STAGES-1] & ~r_sync_d;
    assign {w_sat_now, w_cnt_next} = sat_inc(r_edge_cnt, w_edge);

    // Window FSM; the closing cycle's edge is folded into the reported count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_edge_cnt   <= '0;
            r_timer      <= '0;
            r_sat_flag   <= 1'b0;
            r_meas       <= '0;
            r_ovf        <= 1'b0;
            r_meas_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable | start) begin
                        r_state    <= S_GATE;
                        r_busy     <= 1'b1;
                        r_edge_cnt <= '0;
                        r_timer    <= TIMER_LOAD;
                        r_sat_flag <= 1'b0;
                    end
                end
                S_GATE: begin
                    if (r_timer != '0) begin
                        r_edge_cnt <= w_cnt_next;
                        r_sat_flag <= r_sat_flag | w_sat_now;
                        r_timer    <= r_timer - TW'(1);
                    end else begin
                        r_meas       <= w_cnt_next;
                        r_ovf        <= r_sat_flag | w_sat_now;
                        r_meas_valid <= 1'b1;
                        r_edge_cnt   <= '0;
                        r_timer      <= TIMER_LOAD;
                        r_sat_flag   <= 1'b0;
                        if (!enable) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_dout = r_meas[7:0];
        if (byte_sel)
            w_dout = 8'(r_meas >> 8);
    end

    assign meas       = r_meas;
    assign meas_valid = r_meas_valid;
    assign ovf        = r_ovf;
    assign busy       = r_busy;
    assign dout       = w_dout;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Directed bench for osc_freq_meter: two instances (16-bit / 100-cycle window
// and 9-bit / 1200-cycle window) driven cycle by cycle from one thread.
module tb_osc_freq_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        osc_a, en_a, st_a, bs_a;
    logic [15:0] meas_a;
    logic        mv_a, ovf_a, busy_a;
    logic [7:0]  dout_a;
    logic        osc_b, en_b, st_b, bs_b;
    logic [8:0]  meas_b;
    logic        mv_b, ovf_b, busy_b;
    logic [7:0]  dout_b;

    int n_pass  = 0;
    int n_total = 0;
    int per_a = 0, ph_a = 0, per_b = 0, ph_b = 0;

    osc_freq_meter #(.GATE_CYCLES(100), .CNT_W(16), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst(rst), .osc_in(osc_a), .enable(en_a), .start(st_a),
        .byte_sel(bs_a), .meas(meas_a), .meas_valid(mv_a), .ovf(ovf_a),
        .busy(busy_a), .dout(dout_a)
    );

    osc_freq_meter #(.GATE_CYCLES(1200), .CNT_W(9), .SYNC_STAGES(2)) u_b (
        .clk(clk), .rst(rst), .osc_in(osc_b), .enable(en_b), .start(st_b),
        .byte_sel(bs_b), .meas(meas_b), .meas_valid(mv_b), .ovf(ovf_b),
        .busy(busy_b), .dout(dout_b)
    );

    // Advance one cycle; periodic oscillators are updated when per_x != 0.
    task automatic tick;
        @(posedge clk);
        #1;
        if (per_a != 0) begin
            osc_a = (ph_a < per_a / 2);
            ph_a  = (ph_a + 1) % per_a;
        end
        if (per_b != 0) begin
            osc_b = (ph_b < per_b / 2);
            ph_b  = (ph_b + 1) % per_b;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        n_total++; if (meas_a !== 16'd0) $display("FAIL rst_meas_a: got %0d expected 0", meas_a); else n_pass++;
        n_total++; if (mv_a !== 1'b0) $display("FAIL rst_mv_a: got %b expected 0", mv_a); else n_pass++;
        n_total++; if (ovf_a !== 1'b0) $display("FAIL rst_ovf_a: got %b expected 0", ovf_a); else n_pass++;
        n_total++; if (busy_a !== 1'b0) $display("FAIL rst_busy_a: got %b expected 0", busy_a); else n_pass++;
        n_total++; if (dout_a !== 8'h00) $display("FAIL rst_dout_a: got %h expected 00", dout_a); else n_pass++;
        n_total++; if (meas_b !== 9'd0) $display("FAIL rst_meas_b: got %0d expected 0", meas_b); else n_pass++;
        n_total++; if (busy_b !== 1'b0) $display("FAIL rst_busy_b: got %b expected 0", busy_b); else n_pass++;
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_single_window;
        int pulses;
        int first_at;
        pulses   = 0;
        first_at = -1;
        per_a = 10; ph_a = 0;
        repeat (5) tick();
        st_a = 1'b1;
        for (int i = 1; i <= 101; i++) begin
            tick();
            if (i == 1) st_a = 1'b0;
            if (mv_a) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
            if (i == 50) begin
                n_total++; if (busy_a !== 1'b1) $display("FAIL t1_busy_mid: got %b expected 1", busy_a); else n_pass++;
            end
        end
        n_total++; if (first_at != 101) $display("FAIL t1_latency: got %0d expected 101", first_at); else n_pass++;
        n_total++; if (pulses != 1) $display("FAIL t1_pulses: got %0d expected 1", pulses); else n_pass++;
        n_total++; if (meas_a !== 16'd10) $display("FAIL t1_meas: got %0d expected 10", meas_a); else n_pass++;
        n_total++; if (ovf_a !== 1'b0) $display("FAIL t1_ovf: got %b expected 0", ovf_a); else n_pass++;
        n_total++; if (busy_a !== 1'b0) $display("FAIL t1_busy_end: got %b expected 0", busy_a); else n_pass++;
        tick();
        n_total++; if (mv_a !== 1'b0) $display("FAIL t1_mv_width: got %b expected 0", mv_a); else n_pass++;
        per_a = 0; osc_a = 1'b0;
    endtask

    task automatic test_back_to_back;
        int pulses;
        int sum;
        int pos[3];
        int val[3];
        pulses = 0;
        sum    = 0;
        for (int k = 0; k < 3; k++) begin
            pos[k] = -1;
            val[k] = -1;
        end
        osc_a = 1'b0;
        repeat (12) tick();
        per_a = 7; ph_a = 0; en_a = 1'b1;
        for (int i = 1; i <= 301; i++) begin
            tick();
            if (i == 250) en_a = 1'b0;
            if (mv_a) begin
                if (pulses < 3) begin
                    pos[pulses] = i;
                    val[pulses] = int'(meas_a);
                end
                sum += int'(meas_a);
                pulses++;
            end
            if (i == 101) begin
                n_total++; if (busy_a !== 1'b1) $display("FAIL t2_busy_gap: got %b expected 1", busy_a); else n_pass++;
            end
        end
        n_total++; if (pulses != 3) $display("FAIL t2_pulses: got %0d expected 3", pulses); else n_pass++;
        n_total++; if (pos[0] != 101 || pos[1] != 201 || pos[2] != 301)
            $display("FAIL t2_spacing: got %0d %0d %0d expected 101 201 301", pos[0], pos[1], pos[2]); else n_pass++;
        n_total++; if (val[0] != 14 || val[1] != 15 || val[2] != 14)
            $display("FAIL t2_meas: got %0d %0d %0d expected 14 15 14", val[0], val[1], val[2]); else n_pass++;
        n_total++; if (sum != 43) $display("FAIL t2_sum: got %0d expected 43", sum); else n_pass++;
        n_total++; if (busy_a !== 1'b0) $display("FAIL t2_busy_end: got %b expected 0", busy_a); else n_pass++;
        per_a = 0; osc_a = 1'b0;
    endtask

    task automatic test_reset_abort;
        int pulses;
        pulses = 0;
        per_a = 10; ph_a = 0;
        repeat (3) tick();
        st_a = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (i == 1) st_a = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (mv_a !== 1'b0) $display("FAIL t4_mv: got %b expected 0", mv_a); else n_pass++;
        n_total++; if (meas_a !== 16'd0) $display("FAIL t4_meas: got %0d expected 0", meas_a); else n_pass++;
        n_total++; if (busy_a !== 1'b0) $display("FAIL t4_busy: got %b expected 0", busy_a); else n_pass++;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (mv_a) pulses++;
        end
        n_total++; if (pulses != 0) $display("FAIL t4_no_valid: got %0d pulses expected 0", pulses); else n_pass++;
        st_a = 1'b1;
        for (int i = 1; i <= 101; i++) begin
            tick();
            if (i == 1) st_a = 1'b0;
        end
        n_total++; if (mv_a !== 1'b1) $display("FAIL t4_restart_mv: got %b expected 1", mv_a); else n_pass++;
        n_total++; if (meas_a !== 16'd10) $display("FAIL t4_restart_meas: got %0d expected 10", meas_a); else n_pass++;
        per_a = 0; osc_a = 1'b0;
    endtask

    task automatic test_last_cycle_edge;
        osc_a = 1'b0;
        repeat (6) tick();
        osc_a = 1'b1;           // lands on the IDLE->GATE cycle, must be dropped
        tick();
        osc_a = 1'b0;
        tick();
        en_a = 1'b1;
        for (int i = 1; i <= 201; i++) begin
            tick();
            if (i == 98) osc_a = 1'b1;   // counted on the final cycle of window 1
            if (i == 99) osc_a = 1'b0;
            if (i == 150) en_a = 1'b0;
            if (i == 101) begin
                n_total++; if (mv_a !== 1'b1) $display("FAIL t5_mv1: got %b expected 1", mv_a); else n_pass++;
                n_total++; if (meas_a !== 16'd1) $display("FAIL t5_meas1: got %0d expected 1", meas_a); else n_pass++;
            end
        end
        n_total++; if (mv_a !== 1'b1) $display("FAIL t5_mv2: got %b expected 1", mv_a); else n_pass++;
        n_total++; if (meas_a !== 16'd0) $display("FAIL t5_meas2: got %0d expected 0", meas_a); else n_pass++;
    endtask

    task automatic test_saturation;
        int pulses;
        pulses = 0;
        per_b = 2; ph_b = 0;
        repeat (4) tick();
        st_b = 1'b1;
        for (int i = 1; i <= 1201; i++) begin
            tick();
            if (i == 1) st_b = 1'b0;
            if (mv_b) pulses++;
        end
        n_total++; if (pulses != 1 || mv_b !== 1'b1) $display("FAIL t3_sat_valid: got %0d pulses mv=%b expected 1 mv=1", pulses, mv_b); else n_pass++;
        n_total++; if (meas_b !== 9'd511) $display("FAIL t3_sat_meas: got %0d expected 511", meas_b); else n_pass++;
        n_total++; if (ovf_b !== 1'b1) $display("FAIL t3_sat_ovf: got %b expected 1", ovf_b); else n_pass++;
        per_b = 10; ph_b = 0;
        repeat (5) tick();
        st_b = 1'b1;
        for (int i = 1; i <= 1201; i++) begin
            tick();
            if (i == 1) st_b = 1'b0;
        end
        n_total++; if (mv_b !== 1'b1) $display("FAIL t3_norm_valid: got %b expected 1", mv_b); else n_pass++;
        n_total++; if (meas_b !== 9'd120) $display("FAIL t3_norm_meas: got %0d expected 120", meas_b); else n_pass++;
        n_total++; if (ovf_b !== 1'b0) $display("FAIL t3_norm_ovf: got %b expected 0", ovf_b); else n_pass++;
        per_b = 0; osc_b = 1'b0;
    endtask

    task automatic test_byte_readout;
        osc_b = 1'b0;
        repeat (4) tick();
        st_b = 1'b1;
        for (int i = 1; i <= 1201; i++) begin
            tick();
            if (i == 1) st_b = 1'b0;
            osc_b = (i >= 10 && i <= 850 && (i % 2 == 0));   // 421 pulses
        end
        n_total++; if (meas_b !== 9'h1A5) $display("FAIL t6_meas: got %h expected 1a5", meas_b); else n_pass++;
        bs_b = 1'b0;
        #1;
        n_total++; if (dout_b !== 8'hA5) $display("FAIL t6_dout_lo: got %h expected a5", dout_b); else n_pass++;
        bs_b = 1'b1;
        #1;
        n_total++; if (dout_b !== 8'h01) $display("FAIL t6_dout_hi: got %h expected 01", dout_b); else n_pass++;
        bs_b = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        osc_a = 1'b0; en_a = 1'b0; st_a = 1'b0; bs_a = 1'b0;
        osc_b = 1'b0; en_b = 1'b0; st_b = 1'b0; bs_b = 1'b0;
        test_reset();
        test_single_window();
        test_back_to_back();
        test_reset_abort();
        test_last_cycle_edge();
        test_saturation();
        test_byte_readout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
